aes_stream_host: RTL and testbench

AES_STREAM_HOST -- requirements
Module: aes_stream_host

---
 rtl/aes_stream_pkg.sv | 19 +
 rtl/aes_hold_reg.sv | 37 +++
 rtl/aes_stream_host.sv | 155 +++++++++++++++
 tb/tb_aes_stream_host.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// Shared types and widths for the AES stream host.
package aes_stream_pkg;

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned KEY_W  = 256;
    localparam int unsigned NBLK_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StKey0,
        StKey1,
        StLoad,
        StStart,
        StCollect,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/aes_hold_reg.sv
// Single-entry valid/ready holding register; accepts a new word in the same
// cycle the held one drains.
module aes_hold_reg
    import aes_stream_pkg::*;
#(
    parameter int unsigned W = BLK_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         full_q;
    logic [W-1:0] data_q;

    assign in_ready  = !full_q || out_ready;
    assign out_valid = full_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            full_q <= 1'b1;
            data_q <= in_data;
        end else if (out_ready && full_q) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_stream_host.sv
// Job sequencer feeding a pipelined AES core: key beats, data beats, start strobe,
// then result collection into a downstream stream, guarded by a watchdog.
module aes_stream_host
    import aes_stream_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 4096,
    parameter int unsigned MAX_NBLK = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KEY_W-1:0]  cfg_key,
    input  logic [NBLK_W-1:0] cfg_nblk,
    input  logic              cfg_go,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [BLK_W-1:0]  src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [BLK_W-1:0]  core_in_data,
    output logic              core_in_valid,
    input  logic              core_ready_for_inp,
    output logic              core_start,
    input  logic [BLK_W-1:0]  core_out_data,
    input  logic              core_out_valid,
    output logic              core_ready_to_out,
    output logic [BLK_W-1:0]  snk_data,
    output logic              snk_valid,
    input  logic              snk_ready
);

    localparam logic [15:0] WdLimit = 16'(TIMEOUT);

    state_e            state_q, state_d;
    logic [KEY_W-1:0]  key_q;
    logic [NBLK_W-1:0] nblk_q, tx_cnt_q, rx_cnt_q;
    logic              armed_q, armed_d;
    logic              cap_blk_q, cap_blk_d;
    logic [15:0]       wd_q, wd_d;

    logic             go_ok, have_beat, beat, load_beat, capture, sink_xfer, progress;
    logic             tx_in_ready, tx_full, rx_in_ready, rx_full, rx_drain;
    logic [BLK_W-1:0] tx_data, rx_data;

    assign go_ok = (state_q == StIdle) && cfg_go && (cfg_nblk != '0) &&
                   (32'(cfg_nblk) <= MAX_NBLK);

    assign src_ready = (state_q == StLoad) && !tx_full && tx_in_ready && (tx_cnt_q < nblk_q);

    assign have_beat = (state_q == StKey0) || (state_q == StKey1) ||
                       ((state_q == StLoad) && tx_full);
    assign beat      = have_beat && armed_q && core_ready_for_inp;
    assign load_beat = beat && (state_q == StLoad);

    always_comb begin
        core_in_data = '0;
        if (beat) begin
            unique case (state_q)
                StKey0:  core_in_data = key_q[KEY_W-1:BLK_W];
                StKey1:  core_in_data = key_q[BLK_W-1:0];
                default: core_in_data = tx_data;
            endcase
        end
    end

    assign core_in_valid     = beat;
    assign core_start        = (state_q == StStart);
    assign capture           = (state_q == StCollect) && core_out_valid && !cap_blk_q &&
                               rx_in_ready && (rx_cnt_q < nblk_q);
    assign core_ready_to_out = capture;
    // A stuck job must not keep handing results downstream.
    assign rx_drain          = snk_ready && (state_q != StErr);
    assign snk_valid         = rx_full && (state_q != StErr);
    assign snk_data          = rx_data;
    assign sink_xfer         = snk_valid && snk_ready;
    assign progress          = beat || core_start || capture || sink_xfer;

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign err  = (state_q == StErr);

    aes_hold_reg #(.W(BLK_W)) u_tx (
        .clk       (clk),
        .reset     (reset),
        .in_data   (src_data),
        .in_valid  (src_valid && src_ready),
        .in_ready  (tx_in_ready),
        .out_data  (tx_data),
        .out_valid (tx_full),
        .out_ready (load_beat)
    );

    aes_hold_reg #(.W(BLK_W)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .in_data   (core_out_data),
        .in_valid  (capture),
        .in_ready  (rx_in_ready),
        .out_data  (rx_data),
        .out_valid (rx_full),
        .out_ready (rx_drain)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (go_ok) state_d = StKey0;
            StKey0:    if (beat) state_d = StKey1;
            StKey1:    if (beat) state_d = StLoad;
            StLoad:    if (tx_cnt_q == nblk_q) state_d = StStart;
            StStart:   state_d = StCollect;
            StCollect: if ((rx_cnt_q == nblk_q) && !rx_full) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StErr;
        endcase
        if (busy && (state_q != StErr) && (wd_q >= WdLimit)) state_d = StErr;
    end

    // Re-arm needs the request to be seen low; the beat itself needs it high.
    always_comb begin
        armed_d   = beat ? 1'b0 : (!core_ready_for_inp ? 1'b1 : armed_q);
        cap_blk_d = capture ? 1'b1 : (!core_out_valid ? 1'b0 : cap_blk_q);
        wd_d      = wd_q;
        if ((state_q == StIdle) || progress) wd_d = '0;
        else if (wd_q != '1)                 wd_d = wd_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            key_q     <= '0;
            nblk_q    <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            armed_q   <= 1'b1;
            cap_blk_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            cap_blk_q <= cap_blk_d;
            wd_q      <= wd_d;
            if (go_ok) begin
                key_q    <= cfg_key;
                nblk_q   <= cfg_nblk;
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
            end else begin
                if (load_beat) tx_cnt_q <= tx_cnt_q + 4'd1;
                if (capture)   rx_cnt_q <= rx_cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_stream_host.sv
// Scoreboard bench for aes_stream_host with a behavioural pipelined-core model.
module tb_aes_stream_host;

    localparam logic [255:0] KEY_A =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] cfg_key;
    logic [3:0]   cfg_nblk;
    logic         cfg_go;
    logic         busy, done, err;
    logic [127:0] src_data;
    logic         src_valid, src_ready;
    logic [127:0] core_in_data;
    logic         core_in_valid, core_ready_for_inp, core_start;
    logic [127:0] core_out_data;
    logic         core_out_valid, core_ready_to_out;
    logic [127:0] snk_data;
    logic         snk_valid, snk_ready;

    always #5 clk = ~clk;

    aes_stream_host dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_key            (cfg_key),
        .cfg_nblk           (cfg_nblk),
        .cfg_go             (cfg_go),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .src_data           (src_data),
        .src_valid          (src_valid),
        .src_ready          (src_ready),
        .core_in_data       (core_in_data),
        .core_in_valid      (core_in_valid),
        .core_ready_for_inp (core_ready_for_inp),
        .core_start         (core_start),
        .core_out_data      (core_out_data),
        .core_out_valid     (core_out_valid),
        .core_ready_to_out  (core_ready_to_out),
        .snk_data           (snk_data),
        .snk_valid          (snk_valid),
        .snk_ready          (snk_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int beat_tot = 0;
    int jb = 0;
    int core_mode = 0;  // 0 toggle request, 1 hold request high, 2 stall after key beats
    bit snk_rand = 1'b0;
    bit released = 1'b0;
    bit cooldown = 1'b0;
    logic [255:0] cur_key = '0;
    logic [127:0] src_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] core_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_ctl"}, {busy, done, err, src_ready, core_in_valid, core_start,
                             core_ready_to_out, snk_valid}, '0);
        check({nm, "_data"}, {core_in_data, snk_data}, '0);
    endtask

    task automatic start_job(input logic [255:0] k, input logic [3:0] n);
        @(negedge clk);
        cur_key  = k;
        cfg_key  = k;
        cfg_nblk = n;
        cfg_go   = 1'b1;
        @(negedge clk);
        cfg_go   = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(nm, (done_cnt == d0 + 1), 1'b1);
    endtask

    // Core model: checks key beats, returns CT->PT, anything else inverted.
    initial begin
        core_ready_for_inp = 1'b0;
        core_out_valid     = 1'b0;
        core_out_data      = '0;
        forever begin
            @(negedge clk);
            case (core_mode)
                1:       core_ready_for_inp = 1'b1;
                2:       core_ready_for_inp = (jb >= 2) ? 1'b0 : ~core_ready_for_inp;
                default: core_ready_for_inp = ~core_ready_for_inp;
            endcase
            if (cooldown) begin
                core_out_valid = 1'b0;
                cooldown = 1'b0;
            end else begin
                core_out_valid = released && (core_q.size() > 0);
            end
            core_out_data = core_out_valid ? core_q[0] : '0;
            #4;
            if (reset) begin
                core_q.delete();
                jb = 0;
                released = 1'b0;
                cooldown = 1'b0;
                continue;
            end
            if (core_ready_to_out) check("rto_needs_valid", core_out_valid, 1'b1);
            if (core_in_valid) begin
                check("beat_needs_req", core_ready_for_inp, 1'b1);
                beat_tot++;
                if (jb == 0)      check("key_hi", core_in_data, cur_key[255:128]);
                else if (jb == 1) check("key_lo", core_in_data, cur_key[127:0]);
                else core_q.push_back((core_in_data == CT) ? PT : ~core_in_data);
                jb++;
            end
            if (core_start) begin
                released = 1'b1;
                jb = 0;
            end
            if (core_ready_to_out && core_out_valid) begin
                void'(core_q.pop_front());
                cooldown = 1'b1;
                if (core_q.size() == 0) released = 1'b0;
            end
        end
    end

    initial begin
        src_valid = 1'b0;
        src_data  = '0;
        forever begin
            @(negedge clk);
            src_valid = (src_q.size() > 0);
            src_data  = src_valid ? src_q[0] : '0;
            #4;
            if (reset) begin
                src_q.delete();
                continue;
            end
            if (src_valid && src_ready) void'(src_q.pop_front());
        end
    end

    // Sink monitor: pops the scoreboard on every accepted result.
    initial begin
        snk_ready = 1'b0;
        forever begin
            @(negedge clk);
            snk_ready = snk_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            if (reset) begin
                exp_q.delete();
                continue;
            end
            if (done) done_cnt++;
            if (snk_valid && snk_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL snk_unexpected: got %h want nothing", snk_data);
                end else begin
                    check("snk_data", snk_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int b0, t, t0;
        logic [127:0] x;
        reset = 1'b1; cfg_go = 1'b0; cfg_key = '0; cfg_nblk = '0;
        repeat (3) @(negedge clk);
        #4 check_zero("reset");
        @(negedge clk) reset = 1'b0;

        // Known-answer job.
        src_q.push_back(CT);
        exp_q.push_back(PT);
        start_job(KEY_A, 4'd1);
        wait_done("kat_done", 500);
        repeat (2) @(negedge clk);
        check("kat_idle", {busy, err, done}, 3'b000);
        check("kat_drained", exp_q.size(), 0);

        // Zero-length request is ignored.
        b0 = beat_tot;
        start_job(KEY_A, 4'd0);
        repeat (6) @(negedge clk);
        check("nblk0_busy", busy, 1'b0);
        check("nblk0_beats", beat_tot - b0, 0);

        // 15 blocks, random sink backpressure, plus a cfg_go while busy.
        snk_rand = 1'b1;
        for (int i = 0; i < 15; i++) begin
            x = {4{32'hA5C30000 + 32'(i)}};
            src_q.push_back(x);
            exp_q.push_back(~x);
        end
        start_job(~KEY_A, 4'd15);
        repeat (20) @(negedge clk);
        cfg_key = KEY_A; cfg_nblk = 4'd3; cfg_go = 1'b1;
        @(negedge clk) cfg_go = 1'b0;
        check("busy_go_ignored", busy, 1'b1);
        wait_done("long_done", 3000);
        repeat (3) @(negedge clk);
        check("long_drained", exp_q.size(), 0);
        check("long_idle", busy, 1'b0);
        snk_rand = 1'b0;

        // Request held high: one beat per re-arm.
        core_mode = 1;
        b0 = beat_tot;
        x = 128'h0123456789abcdeffedcba9876543210;
        src_q.push_back(x);
        exp_q.push_back(~x);
        start_job({KEY_A[127:0], KEY_A[255:128]}, 4'd1);
        repeat (30) @(negedge clk);
        check("hold_one_beat", beat_tot - b0, 1);
        core_mode = 0;
        wait_done("rearm_done", 500);
        check("rearm_beats", beat_tot - b0, 3);

        // Core stalls after the key: watchdog error.
        core_mode = 2;
        b0 = beat_tot;
        src_q.push_back(CT);
        src_q.push_back(PT);
        start_job(KEY_A, 4'd2);
        t = 0;
        while (beat_tot - b0 < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("stall_key_beats", beat_tot - b0, 2);
        t0 = cyc;
        while (!err && cyc - t0 < 4400) @(negedge clk);
        check("err_set", err, 1'b1);
        check("err_latency", ((cyc - t0) >= 4050) && ((cyc - t0) <= 4150), 1'b1);
        start_job(KEY_A, 4'd1);
        repeat (100) @(negedge clk);
        check("err_sticky", {err, busy, src_ready, core_start, core_ready_to_out, done, snk_valid},
              7'b1100000);

        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        #4 check_zero("err_reset");
        @(negedge clk) reset = 1'b0;
        core_mode = 0;

        // Reset in the middle of LOAD, then a fresh job.
        b0 = beat_tot;
        src_q.push_back(PT);
        start_job(KEY_A, 4'd3);
        t = 0;
        while (beat_tot - b0 < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("load_reached", {beat_tot - b0 == 3, busy}, 2'b11);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        #4 check_zero("load_reset");
        @(negedge clk) reset = 1'b0;
        src_q.push_back(CT);
        exp_q.push_back(PT);
        src_q.push_back(128'h1);
        exp_q.push_back(~128'h1);
        start_job(~KEY_A, 4'd2);
        wait_done("after_reset_done", 800);
        repeat (2) @(negedge clk);
        check("after_reset_drained", exp_q.size(), 0);
        check("after_reset_flags", {busy, err}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
